pattern_count_engine: RTL and testbench

- Hardware responder for the program-3 string-search task.
- On a start pulse it reads a 5-bit pattern and a 32-byte message from data memory.
- It computes three counts (in-byte matches, bytes containing a match, matches including byte crossings), writes them back to data memory, then raises done.
- Sits beside data memory as a memory master; the test/host side drives start and waits on done.

---
 rtl/prog3_pkg.sv | 22 ++
 rtl/pattern_window_match.sv | 38 +++
 rtl/pattern_count_engine.sv | 130 +++++++++++++
 tb/tb_pattern_count_engine.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/prog3_pkg.sv
// Shared types and defaults for the program-3 pattern count engine.
// Holds the FSM state enum, pattern width and default memory map.
package prog3_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_PAT,
    RD_STR,
    WR_CTB,
    WR_CTO,
    WR_CTS,
    DONE
  } state_t;

  localparam int PAT_W = 5;

  localparam int DEF_PAT_ADDR  = 32;
  localparam int DEF_STR_BASE  = 0;
  localparam int DEF_RES_ADDR  = 67;
  localparam int DEF_STR_BYTES = 32;

endpackage

// File: rtl/pattern_window_match.sv
// Counts 5-bit pattern hits inside a byte and across the previous byte.
// Ports: pat, prev (low nibble of prior byte), cur, first -> inbyte_cnt, crossing_cnt.
module pattern_window_match
  import prog3_pkg::*;
(
  input  logic [PAT_W-1:0] pat,
  input  logic [3:0]       prev,
  input  logic [7:0]       cur,
  input  logic             first,
  output logic [2:0]       inbyte_cnt,
  output logic [2:0]       crossing_cnt
);

  // ext[j+4:j] is window j; j=0..3 lie inside cur,
  // j=4..7 straddle the prev/cur boundary.
  logic [11:0] ext;
  logic [7:0]  hit;

  assign ext = {prev, cur};

  always_comb begin
    hit          = '0;
    inbyte_cnt   = '0;
    crossing_cnt = '0;
    for (int j = 0; j < 8; j++) begin
      hit[j] = (ext[j +: 5] == pat);
    end
    for (int j = 0; j < 4; j++) begin
      inbyte_cnt = inbyte_cnt + 3'(hit[j]);
    end
    if (!first) begin
      for (int j = 4; j < 8; j++) begin
        crossing_cnt = crossing_cnt + 3'(hit[j]);
      end
    end
  end

endmodule

// File: rtl/pattern_count_engine.sv
// Memory-master engine: reads pattern + message, writes ctb/cto/cts, raises done.
// Ports: clk, reset, start -> mem_addr/mem_wr_en/mem_wr_data, mem_rd_data, busy, done.
module pattern_count_engine
  import prog3_pkg::*;
#(
  parameter int PAT_ADDR  = DEF_PAT_ADDR,
  parameter int STR_BASE  = DEF_STR_BASE,
  parameter int STR_BYTES = DEF_STR_BYTES,
  parameter int RES_ADDR  = DEF_RES_ADDR
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(STR_BYTES + 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [PAT_W-1:0] pat;
  logic [3:0]      q;
  logic [7:0]      ctb;
  logic [7:0]      cto;
  logic [7:0]      cts;

  logic [2:0] inb;
  logic [2:0] crs;
  logic [7:0] ctb_nxt;
  logic [7:0] cto_nxt;
  logic [7:0] cts_nxt;

  // In RD_STR, cnt==0 is the pattern cycle; cnt==k consumes byte k-1.
  pattern_window_match u_match (
    .pat          (pat),
    .prev         (q),
    .cur          (mem_rd_data),
    .first        (cnt == CW'(1)),
    .inbyte_cnt   (inb),
    .crossing_cnt (crs)
  );

  assign ctb_nxt = ctb + 8'(inb);
  assign cto_nxt = cto + 8'(inb != 3'd0);
  assign cts_nxt = cts + 8'(inb) + 8'(crs);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      pat         <= '0;
      q           <= '0;
      ctb         <= '0;
      cto         <= '0;
      cts         <= '0;
      mem_addr    <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RD_PAT;
            mem_addr <= 8'(PAT_ADDR);
            busy     <= 1'b1;
            done     <= 1'b0;
            cnt      <= '0;
            q        <= '0;
            ctb      <= '0;
            cto      <= '0;
            cts      <= '0;
          end
        end
        RD_PAT: begin
          state    <= RD_STR;
          mem_addr <= 8'(STR_BASE);
          cnt      <= '0;
        end
        RD_STR: begin
          cnt <= cnt + CW'(1);
          if (cnt < CW'(STR_BYTES - 1)) begin
            mem_addr <= 8'(STR_BASE) + 8'(cnt) + 8'd1;
          end
          if (cnt == '0) begin
            pat <= mem_rd_data[7:3];
          end else begin
            ctb <= ctb_nxt;
            cto <= cto_nxt;
            cts <= cts_nxt;
            q   <= mem_rd_data[3:0];
          end
          // Last byte: its contribution goes straight to the first write.
          if (cnt == CW'(STR_BYTES)) begin
            state       <= WR_CTB;
            mem_wr_en   <= 1'b1;
            mem_addr    <= 8'(RES_ADDR);
            mem_wr_data <= ctb_nxt;
          end
        end
        WR_CTB: begin
          state       <= WR_CTO;
          mem_addr    <= 8'(RES_ADDR + 1);
          mem_wr_data <= cto;
        end
        WR_CTO: begin
          state       <= WR_CTS;
          mem_addr    <= 8'(RES_ADDR + 2);
          mem_wr_data <= cts;
        end
        WR_CTS: begin
          state     <= DONE;
          mem_wr_en <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_count_engine.sv
// Self-checking bench for pattern_count_engine with a bit-string reference model.
// Ports: drives clk/reset/start, models data memory, checks results and timing.
module tb_pattern_count_engine;

  localparam int PA = 32;
  localparam int RA = 67;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;
  logic       busy;
  logic       done;

  logic [7:0] img [256];
  logic [7:0] res [256];
  int wr_cnt = 0;
  int bad_wr = 0;

  int errs = 0;
  int checks = 0;

  pattern_count_engine dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_rd_data <= img[mem_addr];
    if (mem_wr_en) begin
      res[mem_addr] <= mem_wr_data;
      wr_cnt <= wr_cnt + 1;
      if (mem_addr < 8'(RA) || mem_addr > 8'(RA + 2)) bad_wr <= bad_wr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts taken over the message as one 256-bit string, MSB = byte 0 bit 7.
  function automatic void model(output logic [7:0] e0, output logic [7:0] e1,
                                output logic [7:0] e2);
    logic [255:0] s;
    logic [4:0]   p;
    bit           hit [32];
    int           a = 0;
    int           b = 0;
    int           c = 0;
    p = img[PA][7:3];
    for (int k = 0; k < 32; k++) s[255 - 8 * k -: 8] = img[k];
    for (int i = 0; i <= 251; i++) begin
      if (s[255 - i -: 5] == p) begin
        c++;
        if (i % 8 < 4) begin
          a++;
          hit[i / 8] = 1'b1;
        end
      end
    end
    for (int k = 0; k < 32; k++) b += int'(hit[k]);
    e0 = 8'(a);
    e1 = 8'(b);
    e2 = 8'(c);
  endfunction

  task automatic fill(input logic [4:0] p, input logic [7:0] b0,
                      input logic [7:0] b1, input logic [7:0] rest);
    img[PA] = {p, 3'($urandom)};
    img[0] = b0;
    img[1] = b1;
    for (int k = 2; k < 32; k++) img[k] = rest;
  endtask

  task automatic fill_rand();
    logic [4:0] p;
    p = 5'($urandom);
    img[PA] = {p, 3'($urandom)};
    for (int k = 0; k < 32; k++) begin
      if ($urandom_range(0, 2) == 0) img[k] = {p, 3'($urandom)};
      else img[k] = 8'($urandom);
    end
  endtask

  // One start pulse; optional extra starts at t5/t20 or reset at rst_at.
  task automatic run(input string tag, input bit extra, input int rst_at);
    int n;
    int w0;
    int b0;
    logic [7:0] e0, e1, e2;
    model(e0, e1, e2);
    w0 = wr_cnt;
    b0 = bad_wr;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 1;
    chk({tag, " busy@t1"}, 32'(busy), 1);
    chk({tag, " done@t1"}, 32'(done), 0);
    chk({tag, " addr@t1"}, 32'(mem_addr), PA);
    if (rst_at > 0) begin
      while (n < rst_at) begin
        @(posedge clk);
        #1;
        n++;
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk({tag, " rst busy"}, 32'(busy), 0);
      chk({tag, " rst done"}, 32'(done), 0);
      chk({tag, " rst wr_en"}, 32'(mem_wr_en), 0);
      chk({tag, " rst addr"}, 32'(mem_addr), 0);
      repeat (40) @(posedge clk);
      #1;
      chk({tag, " rst no writes"}, 32'(wr_cnt - w0), 0);
      chk({tag, " rst still idle"}, 32'(busy | done), 0);
      return;
    end
    while (!done && n < 100) begin
      start = extra && (n == 5 || n == 20);
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
      if (n == 2) chk({tag, " addr@t2"}, 32'(mem_addr), 0);
    end
    chk({tag, " done cycle"}, 32'(n), 38);
    chk({tag, " busy@done"}, 32'(busy), 0);
    chk({tag, " wr_en@done"}, 32'(mem_wr_en), 0);
    chk({tag, " write count"}, 32'(wr_cnt - w0), 3);
    chk({tag, " stray writes"}, 32'(bad_wr - b0), 0);
    chk({tag, " ctb"}, 32'(res[RA]), 32'(e0));
    chk({tag, " cto"}, 32'(res[RA + 1]), 32'(e1));
    chk({tag, " cts"}, 32'(res[RA + 2]), 32'(e2));
    @(posedge clk);
    #1;
    chk({tag, " done held"}, 32'(done), 1);
  endtask

  initial begin
    for (int k = 0; k < 256; k++) img[k] = 8'hEE;
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset addr", 32'(mem_addr), 0);
    chk("reset wr_en", 32'(mem_wr_en), 0);
    chk("reset wr_data", 32'(mem_wr_data), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    reset = 1'b0;

    fill(5'b00000, 8'h00, 8'h00, 8'h00);
    run("zeros", 1'b0, 0);
    chk("zeros ctb const", 32'(res[RA]), 128);
    chk("zeros cto const", 32'(res[RA + 1]), 32);
    chk("zeros cts const", 32'(res[RA + 2]), 252);

    fill(5'b10101, 8'h55, 8'h55, 8'h55);
    run("alt55", 1'b0, 0);
    chk("alt55 ctb const", 32'(res[RA]), 64);
    chk("alt55 cto const", 32'(res[RA + 1]), 32);
    chk("alt55 cts const", 32'(res[RA + 2]), 126);

    fill(5'b11111, 8'h00, 8'h00, 8'h00);
    run("nomatch", 1'b0, 0);
    chk("nomatch cts const", 32'(res[RA + 2]), 0);

    fill(5'b11111, 8'h0F, 8'hF0, 8'h00);
    run("cross", 1'b0, 0);
    chk("cross ctb const", 32'(res[RA]), 0);
    chk("cross cto const", 32'(res[RA + 1]), 0);
    chk("cross cts const", 32'(res[RA + 2]), 4);

    fill_rand();
    run("extra starts", 1'b1, 0);
    fill_rand();
    run("restart", 1'b0, 0);

    fill_rand();
    run("reset mid", 1'b0, 10);
    run("after reset", 1'b0, 0);

    for (int r = 0; r < 6; r++) begin
      fill_rand();
      run($sformatf("rand%0d", r), 1'b0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
